skew_feeder: RTL and testbench

- Parametrised successor to the single-matrix diagonal extractors. Reads a K-deep tile of LANES-wide words from the operand buffer, one word per row.
- Emits a skewed wavefront onto the systolic array edge: north ports when feeding B, west ports when feeding A. Runtime base, stride and depth select the layout.
- Adds start/busy/done, downstream stall (out_ready), runtime active-lane masking with zero padding, and a drain phase.

---
 rtl/skew_feeder_pkg.sv | 31 +++
 rtl/skew_delay_line.sv | 41 ++++
 rtl/skew_feeder.sv | 247 ++++++++++++++++++++++++
 tb/tb_skew_feeder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_feeder_pkg.sv
// Shared types and width helpers for the skew_feeder operand edge feeder.
package skew_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of the tile-depth field, able to hold 0..max_k.
  function automatic int k_len_w(input int max_k);
    return $clog2(max_k + 1);
  endfunction

  // Width of the active-lane field, able to hold 0..lanes.
  function automatic int n_valid_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // Beat/read counters span a full job of max_k + lanes - 1 beats with headroom.
  function automatic int beat_cnt_w(input int max_k, input int lanes);
    return $clog2(max_k + lanes) + 1;
  endfunction

  // Zero rows injected after the last real row so every lane empties its line.
  function automatic int drain_beats(input int lanes);
    return lanes - 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane skew delay: DEPTH-stage shift register with enable and synchronous
// flush. DEPTH = 0 degenerates to a plain wire.
module skew_delay_line #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, flush, en};
    assign dout        = din;
  end else begin : g_shift
    logic [DATA_WIDTH-1:0] stage [DEPTH];

    // Shift one position per enabled cycle; flush clears every stage.
    // NOTE: non-blocking assignments let every stage read its neighbour's old
    // value, so the loop order does not matter.
    // NOTE: the stages are reset, unlike a RAM, because stale contents would
    // surface as real data on the first beats of the next job.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (flush) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: reads a K-row tile from the operand buffer and emits it as a
// skewed wavefront (lane j delayed by j beats) onto a systolic array edge.
// Optional feature macro SKEW_FEEDER_LANE_MASK_EN adds out_lane_valid.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_K      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rst_flush,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr_in,
  input  logic [ADDR_WIDTH-1:0]         stride_in,
  input  logic [k_len_w(MAX_K)-1:0]     k_len_in,
  input  logic [n_valid_w(LANES)-1:0]   n_valid_in,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_ren,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [LANES*DATA_WIDTH-1:0]   mem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data
`ifdef SKEW_FEEDER_LANE_MASK_EN
  ,
  output logic [LANES-1:0]              out_lane_valid
`endif
);

  localparam int KW          = k_len_w(MAX_K);
  localparam int NW          = n_valid_w(LANES);
  localparam int CW          = beat_cnt_w(MAX_K, LANES);
  localparam int DRAIN_BEATS = drain_beats(LANES);
  localparam int W           = LANES * DATA_WIDTH;

  state_t state_q, state_d;

  // Latched job
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [KW-1:0]         k_q;
  logic [NW-1:0]         nv_q;

  // Progress counters
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] drain_cnt;
  logic [CW-1:0] acc_cnt;

  // Read return tracking and the one-row skid buffer
  logic          rd_pending;
  logic          skid_full;
  logic [W-1:0]  skid_data;

  logic [KW-1:0] k_clamp;
  logic [NW-1:0] nv_clamp;
  logic          active;
  logic          have_row;
  logic          zero_avail;
  logic          out_can;
  logic          load;
  logic          accept;
  logic          skid_next_full;
  logic          last_read_back;
  logic          last_beat;
  logic [CW-1:0] beats_last;

  logic [W-1:0]     row_src;
  logic [W-1:0]     row_in;
  logic [LANES-1:0] lane_real;
  logic [W-1:0]     skewed;

  assign k_clamp  = (k_len_in > KW'(MAX_K))   ? KW'(MAX_K)  : k_len_in;
  assign nv_clamp = (n_valid_in > NW'(LANES)) ? NW'(LANES)  : n_valid_in;

  assign active     = (state_q == FETCH) || (state_q == DRAIN);
  assign have_row   = skid_full || rd_pending;
  assign zero_avail = (state_q == DRAIN) && !skid_full && (drain_cnt < CW'(DRAIN_BEATS));
  assign out_can    = !out_valid || out_ready;
  assign load       = active && (have_row || zero_avail) && out_can && !rst_flush;
  assign accept     = out_valid && out_ready;

  // The skid holds a row that arrived while the output stage could not take it.
  // A read is only issued if that slot is guaranteed empty when its data lands,
  // so no returned row is ever dropped under stall.
  assign skid_next_full = load ? (skid_full && rd_pending) : (skid_full || rd_pending);
  assign mem_ren        = (state_q == FETCH) && (rd_cnt < CW'(k_q)) && !skid_next_full && !rst_flush;
  assign mem_addr       = addr_q;

  assign last_read_back = (state_q == FETCH) && rd_pending && (rd_cnt == CW'(k_q));
  assign beats_last     = CW'(k_q) + CW'(DRAIN_BEATS - 1);
  assign last_beat      = accept && (acc_cnt == beats_last);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status outputs.
  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = (k_len_in == '0) ? DONE : FETCH;
      end
      FETCH:   if (last_read_back) state_d = DRAIN;
      DRAIN:   if (last_beat)      state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_flush) state_d = IDLE;
  end

  // Job latch and progress counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      stride_q  <= '0;
      k_q       <= '0;
      nv_q      <= '0;
      rd_cnt    <= '0;
      drain_cnt <= '0;
      acc_cnt   <= '0;
    end else if (rst_flush) begin
      addr_q    <= '0;
      stride_q  <= '0;
      k_q       <= '0;
      nv_q      <= '0;
      rd_cnt    <= '0;
      drain_cnt <= '0;
      acc_cnt   <= '0;
    end else if (state_q == IDLE && start) begin
      addr_q    <= base_addr_in;
      stride_q  <= stride_in;
      k_q       <= k_clamp;
      nv_q      <= nv_clamp;
      rd_cnt    <= '0;
      drain_cnt <= '0;
      acc_cnt   <= '0;
    end else begin
      if (mem_ren) begin
        addr_q <= addr_q + stride_q;
        rd_cnt <= rd_cnt + CW'(1);
      end
      if (load && !have_row) drain_cnt <= drain_cnt + CW'(1);
      if (accept)            acc_cnt   <= acc_cnt + CW'(1);
    end
  end

  // Track the in-flight read and park a returned row when the output is blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      skid_full  <= 1'b0;
      skid_data  <= '0;
    end else if (rst_flush) begin
      rd_pending <= 1'b0;
      skid_full  <= 1'b0;
      skid_data  <= '0;
    end else begin
      rd_pending <= mem_ren;
      skid_full  <= skid_next_full;
      if (rd_pending && (!load || skid_full)) skid_data <= mem_rdata;
    end
  end

  // Select the next row (oldest first) and zero the inactive lanes.
  always_comb begin
    row_src   = skid_full ? skid_data : mem_rdata;
    row_in    = '0;
    lane_real = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_real[j] = have_row && (j < int'(nv_q));
      if (lane_real[j]) row_in[j*DATA_WIDTH +: DATA_WIDTH] = row_src[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    skew_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (j)
    ) u_data (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (rst_flush),
      .en    (load),
      .din   (row_in[j*DATA_WIDTH +: DATA_WIDTH]),
      .dout  (skewed[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Output stage: loads a new skewed vector whenever the previous beat is gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (rst_flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= skewed;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SKEW_FEEDER_LANE_MASK_EN
  logic [LANES-1:0] skewed_lv;

  for (genvar j = 0; j < LANES; j++) begin : g_lane_lv
    skew_delay_line #(
      .DATA_WIDTH (1),
      .DEPTH      (j)
    ) u_lv (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (rst_flush),
      .en    (load),
      .din   (lane_real[j]),
      .dout  (skewed_lv[j])
    );
  end

  // Lane-valid flags travel through the same skew as the data they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         out_lane_valid <= '0;
    else if (rst_flush) out_lane_valid <= '0;
    else if (load)      out_lane_valid <= skewed_lv;
  end
`else
  // Without the mask port, padding lanes are plain zeros on out_data.
`endif

endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder (LANES=4). Stimulus pushes expected beats;
// a negedge monitor pops and compares every accepted beat.
`timescale 1ns/1ps
module tb_skew_feeder;

  localparam int DW    = 32;
  localparam int LANES = 4;
  localparam int AW    = 8;
  localparam int MAX_K = 16;
  localparam int W     = LANES * DW;
  localparam int KW    = $clog2(MAX_K + 1);
  localparam int NW    = $clog2(LANES + 1);

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          rst_flush  = 1'b0;
  logic          start      = 1'b0;
  logic [AW-1:0] base_addr_in = '0;
  logic [AW-1:0] stride_in  = '0;
  logic [KW-1:0] k_len_in   = '0;
  logic [NW-1:0] n_valid_in = '0;
  logic          busy, done, mem_ren, out_valid;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata  = '0;
  logic          out_ready  = 1'b1;
  logic [W-1:0]  out_data;
`ifdef SKEW_FEEDER_LANE_MASK_EN
  logic [LANES-1:0] out_lane_valid;
`endif

  always #5 clk = ~clk;

  skew_feeder #(
    .DATA_WIDTH (DW),
    .LANES      (LANES),
    .ADDR_WIDTH (AW),
    .MAX_K      (MAX_K)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rst_flush    (rst_flush),
    .start        (start),
    .base_addr_in (base_addr_in),
    .stride_in    (stride_in),
    .k_len_in     (k_len_in),
    .n_valid_in   (n_valid_in),
    .busy         (busy),
    .done         (done),
    .mem_ren      (mem_ren),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef SKEW_FEEDER_LANE_MASK_EN
    ,
    .out_lane_valid (out_lane_valid)
`endif
  );

  // Buffer model: word at address a holds lane j = a + j, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_ren)
      for (int j = 0; j < LANES; j++) mem_rdata[j*DW +: DW] <= DW'(mem_addr) + DW'(j);
  end

  typedef struct packed {
    logic [W-1:0]     data;
    logic [LANES-1:0] lv;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Hand-computed beats for base=0 stride=4 K=4 n_valid=4 (lane order {3,2,1,0}).
  function automatic logic [W-1:0] basic_beat(input int b);
    case (b)
      0:       return {32'd0,  32'd0,  32'd0,  32'd0};
      1:       return {32'd0,  32'd0,  32'd1,  32'd4};
      2:       return {32'd0,  32'd2,  32'd5,  32'd8};
      3:       return {32'd3,  32'd6,  32'd9,  32'd12};
      4:       return {32'd7,  32'd10, 32'd13, 32'd0};
      5:       return {32'd11, 32'd14, 32'd0,  32'd0};
      6:       return {32'd15, 32'd0,  32'd0,  32'd0};
      default: return '0;
    endcase
  endfunction

  function automatic logic [LANES-1:0] basic_lv(input int b);
    case (b)
      0:       return 4'b0001;
      1:       return 4'b0011;
      2:       return 4'b0111;
      3:       return 4'b1111;
      4:       return 4'b1110;
      5:       return 4'b1100;
      6:       return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // Direct formula for the other layouts.
  function automatic beat_t model_beat(input int base, input int stride, input int k,
                                       input int nv, input int b);
    beat_t e;
    int    r;
    e = '0;
    for (int j = 0; j < LANES; j++) begin
      r = b - j;
      if (r >= 0 && r < k && j < nv) begin
        e.data[j*DW +: DW] = DW'(((base + r * stride) % 256) + j);
        e.lv[j]            = 1'b1;
      end
    end
    return e;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got %0h expected no beat", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", out_data, mon_e.data);
`ifdef SKEW_FEEDER_LANE_MASK_EN
        check("beat_lane_valid", W'(out_lane_valid), W'(mon_e.lv));
`endif
      end
    end
  end

  int rec_addr[$];
  int job_first_ren;
  int job_first_valid;

  task automatic run_job(input string tag, input int base, input int stride, input int k_in,
                         input int nv_in, input int st_from, input int st_to,
                         input bit use_hand, input bit poke_start, input int exp_reads);
    int     k_eff, nv_eff, n_beats, cyc, reads, beats, last_beat, done_cyc, stalls;
    bit     finished, frozen, valid_at_done, prev_stalled;
    logic [W-1:0] prev_data;
    k_eff   = (k_in > MAX_K) ? MAX_K : k_in;
    nv_eff  = (nv_in > LANES) ? LANES : nv_in;
    n_beats = (k_eff == 0) ? 0 : k_eff + LANES - 1;
    for (int b = 0; b < n_beats; b++)
      exp_q.push_back(use_hand ? beat_t'({basic_beat(b), basic_lv(b)})
                               : model_beat(base, stride, k_eff, nv_eff, b));
    rec_addr.delete();
    base_addr_in = AW'(base);
    stride_in    = AW'(stride);
    k_len_in     = KW'(k_in);
    n_valid_in   = NW'(nv_in);
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; reads = 0; beats = 0; last_beat = -1; done_cyc = -1; stalls = 0;
    finished = 0; frozen = 1; valid_at_done = 1; prev_stalled = 0; prev_data = '0;
    job_first_ren = -1; job_first_valid = -1;
    while (!finished && cyc < 200) begin
      out_ready = !(cyc >= st_from && cyc < st_to);
      start     = poke_start && (cyc == 2);
      if (start) begin k_len_in = KW'(1); base_addr_in = 8'd100; end
      @(negedge clk);
      if (mem_ren) begin
        reads++;
        rec_addr.push_back(int'(mem_addr));
        if (job_first_ren < 0) job_first_ren = cyc;
      end
      if (out_valid && job_first_valid < 0) job_first_valid = cyc;
      if (prev_stalled && (!out_valid || out_data !== prev_data)) frozen = 0;
      prev_stalled = out_valid && !out_ready;
      if (prev_stalled) stalls++;
      prev_data = out_data;
      if (out_valid && out_ready) begin beats++; last_beat = cyc; end
      if (done) begin done_cyc = cyc; valid_at_done = out_valid; finished = 1; end
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (!finished) begin
      n_checks++;
      $display("FAIL %s_timeout: got no done expected done within 200 cycles", tag);
    end
    check({tag, "_reads"}, W'(reads), W'(exp_reads));
    check({tag, "_beats"}, W'(beats), W'(n_beats));
    check({tag, "_done_cycle"}, W'(done_cyc), (k_eff == 0) ? W'(1) : W'(last_beat + 1));
    check({tag, "_valid_at_done"}, W'(valid_at_done), W'(0));
    check({tag, "_queue_empty"}, W'(exp_q.size()), W'(0));
    if (st_to > st_from) begin
      check({tag, "_stall_frozen"}, W'(frozen), W'(1));
      check({tag, "_stall_cycles"}, W'(stalls), W'(st_to - st_from));
    end
    @(negedge clk);
    check({tag, "_idle_after"}, W'({busy, done}), W'(0));
    exp_q.delete();
  endtask

  initial begin
    bit saw_done;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_mem_ren", W'(mem_ren), W'(0));
    check("rst_mem_addr", W'(mem_addr), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, '0);
    @(posedge clk); #1;

    run_job("basic", 0, 4, 4, 4, 0, 0, 1'b1, 1'b0, 4);
    check("basic_first_ren", W'(job_first_ren), W'(1));
    check("basic_first_valid", W'(job_first_valid), W'(3));

    @(posedge clk); #1;
    run_job("stall", 0, 4, 4, 4, 4, 7, 1'b1, 1'b0, 4);

    @(posedge clk); #1;
    run_job("mask", 0, 4, 4, 2, 0, 0, 1'b0, 1'b1, 4);

    @(posedge clk); #1;
    run_job("wrap", 250, 4, 4, 4, 0, 0, 1'b0, 1'b0, 4);
    check("wrap_addr_count", W'(rec_addr.size()), W'(4));
    if (rec_addr.size() == 4) begin
      check("wrap_addr0", W'(rec_addr[0]), W'(250));
      check("wrap_addr1", W'(rec_addr[1]), W'(254));
      check("wrap_addr2", W'(rec_addr[2]), W'(2));
      check("wrap_addr3", W'(rec_addr[3]), W'(6));
    end

    @(posedge clk); #1;
    run_job("k_zero", 0, 4, 0, 4, 0, 0, 1'b0, 1'b0, 0);

    @(posedge clk); #1;
    run_job("k_clamp", 0, 1, 20, 4, 0, 0, 1'b0, 1'b0, 16);

    // Abort with rst_flush while beat 2 is on the edge.
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) exp_q.push_back(beat_t'({basic_beat(b), basic_lv(b)}));
    base_addr_in = 8'd0; stride_in = 8'd4; k_len_in = KW'(4); n_valid_in = NW'(4);
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    saw_done = 0;
    for (int c = 1; c <= 5; c++) begin
      rst_flush = (c == 5);
      @(negedge clk);
      if (done) saw_done = 1;
      @(posedge clk); #1;
    end
    rst_flush = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(busy), W'(0));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_out_data", out_data, '0);
    for (int c = 0; c < 4; c++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    check("abort_no_done", W'(saw_done), W'(0));
    check("abort_queue_empty", W'(exp_q.size()), W'(0));
    exp_q.delete();
    @(posedge clk); #1;
    run_job("after_abort", 0, 4, 4, 4, 0, 0, 1'b1, 1'b0, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
